// File: rtl/usb_bit_stuffer_hs.sv
// ---------------------------------------------------------------------------
// usb_bit_stuffer_hs
//
// USB high-speed TX bit stuffer. A 0 is inserted after MAX_RUN consecutive
// 1s. The input is stalled for the slot that the stuffed 0 occupies. Both
// sides use valid/ready handshakes. The block also tracks packet boundaries
// and keeps a saturating count of the stuffed bits.
//
// Optional feature (compile-time macro USB_STUFF_NRZI_EN):
//   defined   - out_bit carries the NRZI line level. The level is encoded
//               after stuffing. Idle level is J (1), and the level returns to
//               1 after the last slot of a packet has transferred.
//   undefined - out_bit is the raw stuffed bit.
//
// Parameters
//   MAX_RUN    ones in a row that trigger a stuffed 0 (2..15)
//   CNT_W      width of the stuffed-bit counter
//
// Ports
//   clk        clock
//   nRST       asynchronous reset, active-low
//   in_bit     raw data bit from the serialiser
//   in_valid   in_bit / in_last are valid
//   in_last    in_bit is the final bit of the packet
//   in_ready   block accepts a bit this cycle (combinational)
//   out_bit    stuffed bit, or the line level when NRZI is enabled
//   out_valid  out_bit is valid
//   out_last   final output slot of the packet
//   out_ready  downstream accepts out_bit this cycle
//   stuff_clr  synchronous clear of stuff_cnt (wins over an increment)
//   stuff_cnt  number of stuffed 0s inserted; saturates at all-ones
// ---------------------------------------------------------------------------
module usb_bit_stuffer_hs #(
  parameter int MAX_RUN = 6,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  input  logic             stuff_clr,
  output logic [CNT_W-1:0] stuff_cnt
);

  localparam int                RUN_W   = $clog2(MAX_RUN + 1);
  localparam logic [RUN_W-1:0]  RUN_TOP = RUN_W'(MAX_RUN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_STUFF  = 1'b1
  } state_t;

  state_t           state_r;
  logic [RUN_W-1:0] run_cnt_r;
  logic             last_pend_r;

  logic ld_s;     // output register may load this cycle
  logic xfer_s;   // input handshake completes this cycle
  logic raw_s;    // raw (pre-encoding) bit for the next output slot
  logic line_s;   // value loaded into out_bit for that slot

  // Saturating increment of the statistics counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_MAX) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

`ifdef USB_STUFF_NRZI_EN
  logic lvl_r;
  logic lvl_base_s;

  // NRZI: a 0 toggles the line and a 1 holds it.
  function automatic logic nrzi_next(input logic lvl, input logic raw);
    nrzi_next = raw ? lvl : ~lvl;
  endfunction
`endif

  // Handshake decode and next-slot bit selection.
  always_comb begin
    ld_s     = !out_valid || out_ready;
    in_ready = ld_s && (state_r == ST_NORMAL);
    xfer_s   = in_valid && in_ready;
    if (state_r == ST_STUFF) begin
      raw_s = 1'b0;
    end else begin
      raw_s = in_bit;
    end
`ifdef USB_STUFF_NRZI_EN
    // A last slot leaving this cycle returns the line to J before the next bit.
    if (out_valid && out_ready && out_last) begin
      lvl_base_s = 1'b1;
    end else begin
      lvl_base_s = lvl_r;
    end
    line_s = nrzi_next(lvl_base_s, raw_s);
`else
    line_s = raw_s;
`endif
  end

`ifdef USB_STUFF_NRZI_EN
  // Line-level register. It is updated on every load so idle also returns to J.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      lvl_r <= 1'b1;
    end else if (ld_s) begin
      if (xfer_s || (state_r == ST_STUFF)) begin
        lvl_r <= line_s;
      end else begin
        lvl_r <= lvl_base_s;
      end
    end
  end
`endif

  // Stuffing FSM together with its registered outputs.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_r     <= ST_NORMAL;
      run_cnt_r   <= {RUN_W{1'b0}};
      last_pend_r <= 1'b0;
      out_bit     <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else if (ld_s) begin
      case (state_r)
        ST_NORMAL: begin
          if (xfer_s) begin
            out_bit   <= line_s;
            out_valid <= 1'b1;
            if (in_bit && (run_cnt_r == RUN_TOP)) begin
              // The run is complete. The packet's last flag moves to the stuffed slot.
              state_r     <= ST_STUFF;
              last_pend_r <= in_last;
              out_last    <= 1'b0;
              run_cnt_r   <= {RUN_W{1'b0}};
            end else begin
              out_last <= in_last;
              if (!in_bit || in_last) begin
                run_cnt_r <= {RUN_W{1'b0}};
              end else begin
                run_cnt_r <= run_cnt_r + {{(RUN_W-1){1'b0}}, 1'b1};
              end
            end
          end else begin
            // An idle slot keeps run_cnt, so a run can span a gap inside a packet.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        ST_STUFF: begin
          out_bit   <= line_s;
          out_valid <= 1'b1;
          out_last  <= last_pend_r;
          run_cnt_r <= {RUN_W{1'b0}};
          state_r   <= ST_NORMAL;
        end
        default: begin
          state_r   <= ST_NORMAL;
          run_cnt_r <= {RUN_W{1'b0}};
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

  // Stuffed-bit statistics. A clear wins over a simultaneous increment.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      stuff_cnt <= {CNT_W{1'b0}};
    end else if (stuff_clr) begin
      stuff_cnt <= {CNT_W{1'b0}};
    end else if (ld_s && (state_r == ST_STUFF)) begin
      stuff_cnt <= sat_inc(stuff_cnt);
    end
  end

endmodule
